// File: rtl/mult_div.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Shift-add multiply and restoring divide, one bit per cycle.
module mult_div #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        flush,
   input  logic [5:0]  funct,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   output logic        stall_req,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        done
);

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [4:0] LAST    = 5'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic [63:0] acc;
   logic [31:0] divr;
   logic        op_mul;
   logic        neg_q;
   logic        neg_r;

   logic        is_mul;
   logic        is_div;
   logic        is_sgn;
   logic        start;
   logic [31:0] abs_a;
   logic [31:0] abs_b;

   assign is_mul = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div = (funct == F_DIV) || (funct == F_DIVU);
   assign is_sgn = (funct == F_MULT) || (funct == F_DIV);
   assign start  = is_mul || (is_div && (operand_2 != 32'd0));
   assign abs_a  = (is_sgn && operand_1[31]) ? -operand_1 : operand_1;
   assign abs_b  = (is_sgn && operand_2[31]) ? -operand_2 : operand_2;

   // acc low half holds multiplier / dividend bits still to be consumed
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   logic [32:0] rem_sh;
   logic [31:0] rem_sub;
   logic [63:0] div_nxt;
   logic [63:0] step;
   logic [63:0] prod;
   logic [31:0] quo;
   logic [31:0] rem;

   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divr} : 33'd0);
   assign mul_nxt = {mul_sum, acc[31:1]};
   assign rem_sh  = acc[63:31];
   assign rem_sub = rem_sh[31:0] - divr;
   assign div_nxt = (rem_sh >= {1'b0, divr}) ?
                    {rem_sub, acc[30:0], 1'b1} :
                    {acc[62:0], 1'b0};
   assign step    = op_mul ? mul_nxt : div_nxt;
   assign prod    = neg_q ? -step : step;
   assign quo     = neg_q ? -step[31:0] : step[31:0];
   assign rem     = neg_r ? -step[63:32] : step[63:32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= 5'd0;
         acc    <= 64'd0;
         divr   <= 32'd0;
         op_mul <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= 32'd0;
         lo     <= 32'd0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= 5'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (en) begin
                  if (start) begin
                     acc    <= {32'd0, is_mul ? abs_b : abs_a};
                     divr   <= is_mul ? abs_a : abs_b;
                     op_mul <= is_mul;
                     neg_q  <= is_sgn && (operand_1[31] ^ operand_2[31]);
                     neg_r  <= is_sgn && operand_1[31] && !is_mul;
                     cnt    <= 5'd0;
                     state  <= BUSY;
                  end else if (is_div) begin
                     state <= DONE;
                  end else if (funct == F_MTHI) begin
                     hi <= operand_1;
                  end else if (funct == F_MTLO) begin
                     lo <= operand_1;
                  end
               end
            end
            BUSY: begin
               acc <= step;
               cnt <= cnt + 5'd1;
               if (cnt == LAST) begin
                  if (op_mul) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else begin
                     hi <= rem;
                     lo <= quo;
                  end
                  cnt   <= 5'd0;
                  state <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall_req = rst && !flush &&
                      (((state == IDLE) && en && start) || (state == BUSY));
   assign done      = (state == DONE);
   assign result    = (funct == F_MFHI) ? hi :
                      (funct == F_MFLO) ? lo : 32'd0;

endmodule
